// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
//   stateE     : refill controller state (IDLE / REFILL)
//   NOP        : instruction returned whenever the lookup misses
//   tagSize()  : tag width derived from index/offset widths (32-bit byte
//                addresses, word granularity)
package icache_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } stateE;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int tagSize(input int indexSize, input int offsetSize);
    return 30 - indexSize - offsetSize;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Flop arrays with a combinational read port.
//   clk, reset  : clock, synchronous active-high reset (clears valid bits only)
//   flush       : clears every valid bit at the clock edge (wins over validSet)
//   rdIndex/rdOffset/rdTag -> rdHit, rdData : combinational lookup
//   wrEn, wrIndex, wrOffset, wrData         : one refill word write
//   tagWrEn, wrTag                          : tag write at end of refill
//   validSet                                : mark line wrIndex valid
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_SIZE  = 4,
  parameter int OFFSET_SIZE = 2,
  localparam int TAG_SIZE   = tagSize(INDEX_SIZE, OFFSET_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [INDEX_SIZE-1:0]  rdIndex,
  input  logic [OFFSET_SIZE-1:0] rdOffset,
  input  logic [TAG_SIZE-1:0]    rdTag,
  output logic                   rdHit,
  output logic [31:0]            rdData,
  input  logic                   wrEn,
  input  logic [INDEX_SIZE-1:0]  wrIndex,
  input  logic [OFFSET_SIZE-1:0] wrOffset,
  input  logic [31:0]            wrData,
  input  logic                   tagWrEn,
  input  logic [TAG_SIZE-1:0]    wrTag,
  input  logic                   validSet
);

  localparam int LINES = 1 << INDEX_SIZE;
  localparam int WORDS = 1 << OFFSET_SIZE;

  logic [LINES-1:0]    validQ;
  logic [TAG_SIZE-1:0] tagMem  [LINES];
  logic [31:0]         dataMem [LINES][WORDS];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      validQ <= '0;
    end else if (validSet) begin
      validQ[wrIndex] <= 1'b1;
    end
  end

  // Tag and data contents are never reset; validQ alone qualifies them.
  always_ff @(posedge clk) begin
    if (tagWrEn) begin
      tagMem[wrIndex] <= wrTag;
    end
    if (wrEn) begin
      dataMem[wrIndex][wrOffset] <= wrData;
    end
  end

  assign rdHit  = validQ[rdIndex] && (tagMem[rdIndex] == rdTag);
  assign rdData = dataMem[rdIndex][rdOffset];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache.
// Hits return the instruction combinationally with imem_wait=0; a miss
// stalls the core and refills the whole line, word 0 first, one word per
// mem_ack.
//   clk, reset           : clock, synchronous active-high reset
//   imem_req             : core fetch request
//   imem_pc_addr[31:0]   : fetch byte address (bits [1:0] ignored)
//   imem_instn[31:0]     : instruction (NOP on miss)
//   imem_wait            : core must stall this cycle
//   icache_flush         : one-cycle pulse, invalidates all lines
//   mem_req, mem_addr    : backing-memory word read request / address
//   mem_ack, mem_rdata   : request accepted, refill word valid this cycle
module icache_dm
  import icache_pkg::*;
#(
  parameter int INDEX_SIZE  = 4,
  parameter int OFFSET_SIZE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_req,
  input  logic [31:0] imem_pc_addr,
  output logic [31:0] imem_instn,
  output logic        imem_wait,
  input  logic        icache_flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int TAG_SIZE = tagSize(INDEX_SIZE, OFFSET_SIZE);
  localparam int BASE_W   = 30 - OFFSET_SIZE;
  localparam logic [OFFSET_SIZE-1:0] LAST_BEAT = '1;

  stateE                  state, stateNext;
  logic [OFFSET_SIZE-1:0] beat, beatNext;
  logic [BASE_W-1:0]      lineBase, lineBaseNext;
  logic                   flushSeen, flushSeenNext;

  logic [OFFSET_SIZE-1:0] pcOffset;
  logic [INDEX_SIZE-1:0]  pcIndex;
  logic [TAG_SIZE-1:0]    pcTag;
  logic                   arrayHit;
  logic [31:0]            arrayData;
  logic                   hit;
  logic                   beatAck;
  logic                   lastBeat;
  logic                   unusedPcBits;

  assign pcOffset     = imem_pc_addr[OFFSET_SIZE+1:2];
  assign pcIndex      = imem_pc_addr[OFFSET_SIZE+INDEX_SIZE+1:OFFSET_SIZE+2];
  assign pcTag        = imem_pc_addr[31:32-TAG_SIZE];
  assign unusedPcBits = ^imem_pc_addr[1:0];

  // Everything misses while reset is held.
  assign hit      = arrayHit && !reset;
  assign beatAck  = mem_req && mem_ack;
  assign lastBeat = beatAck && (beat == LAST_BEAT);

  icache_array #(
    .INDEX_SIZE (INDEX_SIZE),
    .OFFSET_SIZE(OFFSET_SIZE)
  ) uArray (
    .clk     (clk),
    .reset   (reset),
    .flush   (icache_flush),
    .rdIndex (pcIndex),
    .rdOffset(pcOffset),
    .rdTag   (pcTag),
    .rdHit   (arrayHit),
    .rdData  (arrayData),
    .wrEn    (beatAck),
    .wrIndex (lineBase[INDEX_SIZE-1:0]),
    .wrOffset(beat),
    .wrData  (mem_rdata),
    .tagWrEn (lastBeat),
    .wrTag   (lineBase[BASE_W-1:INDEX_SIZE]),
    // A flush seen at any point during this refill leaves the line invalid.
    .validSet(lastBeat && !icache_flush && !flushSeen)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      flushSeen <= 1'b0;
    end else begin
      state     <= stateNext;
      beat      <= beatNext;
      flushSeen <= flushSeenNext;
    end
  end

  always_ff @(posedge clk) begin
    lineBase <= lineBaseNext;
  end

  always_comb begin
    stateNext     = state;
    beatNext      = beat;
    lineBaseNext  = lineBase;
    flushSeenNext = flushSeen;
    mem_req       = 1'b0;
    mem_addr      = '0;
    imem_wait     = imem_req && (!hit || (state != IDLE));
    imem_instn    = hit ? arrayData : NOP;

    unique case (state)
      IDLE: begin
        if (imem_req && !hit && !icache_flush) begin
          stateNext     = REFILL;
          beatNext      = '0;
          lineBaseNext  = imem_pc_addr[31:OFFSET_SIZE+2];
          flushSeenNext = 1'b0;
        end
      end
      REFILL: begin
        mem_req  = !reset;
        mem_addr = reset ? 32'h0 : {lineBase, beat, 2'b00};
        if (icache_flush) begin
          flushSeenNext = 1'b1;
        end
        // Once started, the line always completes, regardless of imem_req
        // or address changes.
        if (beatAck) begin
          beatNext = beat + OFFSET_SIZE'(1);
          if (beat == LAST_BEAT) begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemPcAddr;
  logic [31:0] imemInstn;
  logic        imemWait;
  logic        icacheFlush;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memRdata;

  int total = 0;
  int bad   = 0;
  int ackLat = 2;
  int waitCnt = 0;
  int ackCount = 0;
  logic ackStray = 1'b0;

  logic [31:0] expAddrQ[$];
  logic [31:0] expInstnQ[$];

  always #5 clk = ~clk;

  icache_dm dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imemReq),
    .imem_pc_addr(imemPcAddr),
    .imem_instn  (imemInstn),
    .imem_wait   (imemWait),
    .icache_flush(icacheFlush),
    .mem_req     (memReq),
    .mem_addr    (memAddr),
    .mem_ack     (memAck),
    .mem_rdata   (memRdata)
  );

  // Backing memory: 0x100..0x10C = A0..A3, 0x200..0x20C = B0..B3.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'hA0 + {30'd0, a[3:2]};
    if (a[31:4] == 28'h0000020) return 32'hB0 + {30'd0, a[3:2]};
    return 32'hDEAD_BEEF;
  endfunction

  assign memAck   = (memReq && (waitCnt == ackLat)) || ackStray;
  assign memRdata = memWord(memAddr);

  always @(posedge clk) begin
    if (memReq && !memAck) waitCnt <= waitCnt + 1;
    else                   waitCnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected refill addresses on each accepted beat and
  // expected instructions on each delivered fetch.
  always @(negedge clk) begin
    if (!reset && memReq && memAck) begin
      ackCount++;
      if (expAddrQ.size() == 0) check("memAddrUnexpected", memAddr, 32'hFFFF_FFFF);
      else check("memAddr", memAddr, expAddrQ.pop_front());
    end
    if (!reset && imemReq && !imemWait) begin
      if (expInstnQ.size() == 0) check("instnUnexpected", imemInstn, 32'hFFFF_FFFF);
      else check("instn", imemInstn, expInstnQ.pop_front());
    end
  end

  task automatic expectLine(input logic [31:0] base);
    for (int i = 0; i < 4; i++) expAddrQ.push_back(base + 32'(i * 4));
  endtask

  // Called at posedge+1; returns at posedge+1 with imemReq dropped.
  task automatic fetch(input logic [31:0] a, input logic [31:0] expI,
                       input int expWaits, input int flushAfterAcks);
    int waits;
    int base;
    bit flushed;
    waits = 0;
    base = ackCount;
    flushed = 0;
    expInstnQ.push_back(expI);
    imemReq = 1'b1;
    imemPcAddr = a;
    forever begin
      @(negedge clk);
      if (!imemWait) break;
      waits++;
      if (waits > 200) begin
        total++;
        bad++;
        $display("FAIL fetchTimeout: addr %h still waiting after %0d cycles", a, waits);
        break;
      end
      @(posedge clk); #1;
      icacheFlush = 1'b0;
      if (flushAfterAcks >= 0 && !flushed && (ackCount - base) == flushAfterAcks) begin
        icacheFlush = 1'b1;
        flushed = 1;
      end
    end
    check("waitCycles", 32'(waits), 32'(expWaits));
    if (expWaits == 0) check("hitNoMemReq", {31'd0, memReq}, 32'd0);
    @(posedge clk); #1;
    imemReq = 1'b0;
    icacheFlush = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    reset = 1'b1;
    imemReq = 1'b1;
    imemPcAddr = 32'h104;
    icacheFlush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("resetWait", {31'd0, imemWait}, 32'd1);
    check("resetInstn", imemInstn, 32'h0000_0013);
    check("resetMemReq", {31'd0, memReq}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    imemReq = 1'b0;
    @(negedge clk);
    check("idleMemReq", {31'd0, memReq}, 32'd0);
    check("idleMemAddr", memAddr, 32'd0);
    check("idleWait", {31'd0, imemWait}, 32'd0);
    @(posedge clk); #1;

    // Cold miss, 2-cycle ack latency: 1 miss cycle + 4*3 refill cycles.
    ackLat = 2;
    expectLine(32'h100);
    fetch(32'h104, 32'hA1, 13, -1);
    fetch(32'h108, 32'hA2, 0, -1);
    // Conflict eviction on index 0.
    expectLine(32'h200);
    fetch(32'h200, 32'hB0, 13, -1);
    expectLine(32'h100);
    fetch(32'h100, 32'hA0, 13, -1);

    // Zero-latency memory: 5 stall cycles, instruction on the 6th.
    ackLat = 0;
    expectLine(32'h200);
    fetch(32'h200, 32'hB0, 5, -1);
    fetch(32'h20C, 32'hB3, 0, -1);

    // Flush after fill.
    expectLine(32'h100);
    fetch(32'h104, 32'hA1, 5, -1);
    fetch(32'h100, 32'hA0, 0, -1);
    icacheFlush = 1'b1;
    @(posedge clk); #1;
    icacheFlush = 1'b0;
    expectLine(32'h100);
    fetch(32'h104, 32'hA1, 5, -1);

    // Flush during beat 2: the line refills twice before it hits.
    expectLine(32'h200);
    expectLine(32'h200);
    fetch(32'h204, 32'hB1, 10, 2);

    // Stray ack while idle is ignored.
    ackStray = 1'b1;
    @(negedge clk);
    check("strayMemReq", {31'd0, memReq}, 32'd0);
    @(posedge clk); #1;
    ackStray = 1'b0;
    fetch(32'h208, 32'hB2, 0, -1);

    // Reset during beat 1 of a refill.
    ackLat = 2;
    base = ackCount;
    expAddrQ.push_back(32'h100);
    imemReq = 1'b1;
    imemPcAddr = 32'h104;
    n = 0;
    while ((ackCount - base) < 1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("beat0Ack", 32'(ackCount - base), 32'd1);
    reset = 1'b1;
    imemReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("postResetMemReq", {31'd0, memReq}, 32'd0);
    check("postResetMemAddr", memAddr, 32'd0);
    check("postResetWait", {31'd0, imemWait}, 32'd0);
    @(posedge clk); #1;
    expectLine(32'h100);
    fetch(32'h104, 32'hA1, 13, -1);

    repeat (2) @(posedge clk);
    check("addrQueueEmpty", 32'(expAddrQ.size()), 32'd0);
    check("instnQueueEmpty", 32'(expInstnQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the core's instruction-fetch port (imem_req, imem_pc_addr, imem_instn, imem_wait) and a single-word-per-beat backing instruction memory.
- A hit returns the instruction combinationally in the same cycle, with imem_wait=0.
- A miss raises imem_wait and refills the whole line word by word. The core holds its fetch PC stalled for the duration.

Parameters:
- INDEX_SIZE, 4, log2 of line count (16 lines).
- OFFSET_SIZE, 2, log2 of words per line (4 words = 16 B).
- TAG_SIZE, derived: 30-INDEX_SIZE-OFFSET_SIZE (24 at defaults); localparam, not overridable.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  in  1  core fetch request valid.
- imem_pc_addr  in  32  fetch byte address; bits [1:0] ignored.
- imem_instn  out  32  instruction word; valid when imem_req & !imem_wait.
- imem_wait  out  1  core must stall fetch this cycle.
- icache_flush  in  1  single-cycle pulse; invalidates every line.
- mem_req  out  1  backing-memory word read request.
- mem_addr  out  32  word-aligned refill address.
- mem_ack  in  1  backing memory has accepted the request; mem_rdata is valid this cycle.
- mem_rdata  in  32  refill data word.

Behaviour:
- Address split:
  - offset = addr[OFFSET_SIZE+1:2]
  - index = addr[OFFSET_SIZE+INDEX_SIZE+1:OFFSET_SIZE+2]
  - tag = addr[31:32-TAG_SIZE]
- Storage:
  - valid[2^INDEX_SIZE], tag[2^INDEX_SIZE], data[2^INDEX_SIZE][2^OFFSET_SIZE].
  - Flop arrays with combinational read.
- hit = valid[index] & (tag[index]==addr tag); combinational from imem_pc_addr.
- imem_wait = imem_req & (!hit | state!=IDLE); combinational.
- imem_instn = data[index][offset] on hit, else 32'h0000_0013 (NOP).
- FSM states: IDLE, REFILL.
  - IDLE -> REFILL when imem_req & !hit & !icache_flush.
  - On that transition, latch the line base address (imem_pc_addr[31:OFFSET_SIZE+2]) and clear the beat counter.
- REFILL operation:
  - mem_req=1 and mem_addr = {line_base, beat, 2'b00}.
  - On each mem_ack: write mem_rdata into data[latched index][beat], then beat++.
  - mem_ack may arrive in the same cycle mem_req first rises; zero wait beats are legal.
  - mem_req stays high back-to-back between beats.
- Last beat (beat == 2^OFFSET_SIZE-1 with mem_ack):
  - Write the tag, set valid, return to IDLE.
  - The next cycle hits, so miss-to-instruction latency is (sum of beat latencies)+1 cycles.
- Refill is words 0..N-1 in order. There is no critical-word-first and no early restart.
- Address change during REFILL (e.g. redirect): the latched line still completes. The lookup then uses the current imem_pc_addr.
- imem_req deasserted during REFILL: refill still completes; mem_req is never dropped mid-line.
- icache_flush:
  - Clears all valid bits at the clock edge.
  - If asserted during REFILL, the current refill finishes its beats but its valid bit is not set.
  - Flush has priority over a same-cycle last-beat valid set and over IDLE->REFILL.
- Reset (synchronous, any state, including mid-refill), next cycle:
  - state=IDLE, beat=0, all valid=0, mem_req=0, mem_addr=0.
  - Tag and data arrays are not reset.
  - A mem_ack received while in IDLE is ignored.
- Outputs while reset is held:
  - mem_req=0.
  - imem_wait = imem_req (everything misses).
  - imem_instn = NOP.
- No writes from the core side; the cache is never dirty.

Decomposition:
- Shared package icache_pkg:
  - state enum typedef {IDLE, REFILL}.
  - NOP constant 32'h0000_0013.
  - Width helper functions deriving TAG_SIZE.
- One sub-module, icache_array: valid/tag/data storage with combinational read port, write port and flush-clear. The FSM, beat counter and memory interface stay in icache_dm.

Test Plan:
- Cold miss (memory acks 2 cycles after each mem_req), after reset, with backing words at 0x100..0x10C = 0xA0,0xA1,0xA2,0xA3:
  - Stimulus: imem_req=1, addr 0x0000_0104.
  - Response: imem_wait=1; mem_addr sequences 0x100,0x104,0x108,0x10C; imem_wait falls the cycle after the 4th ack, with imem_instn=0xA1.
- Hit after fill: addr 0x108 -> imem_wait=0 in the same cycle, imem_instn=0xA2, mem_req stays 0.
- Conflict eviction:
  - Stimulus: addr 0x200 (index 0, tag 0x2), which refills from 0x200..0x20C.
  - Response: a later 0x100 access misses again and re-issues 4 requests.
- Zero-latency memory (mem_ack tied to mem_req): miss completes in 4 cycles of REFILL plus 1; hit returns on cycle 6 from the miss cycle.
- Flush:
  - After filling line 0, pulse icache_flush -> 0x104 misses.
  - Flush during beat 2 of a refill -> all 4 beats complete, yet the line is still a miss afterwards.
- Reset mid-refill: assert reset during beat 1 -> next cycle mem_req=0, state IDLE; a subsequent 0x104 access triggers a full 4-beat refill starting at 0x100.
